// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side sram-like responder.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional build macro used by the top: DATA_SRAM_STALL_EN.
package data_sram_responder_pkg;

  // Access size encodings carried on data_sram_size (wstrb is what governs writes).
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 3;
  localparam int ENTRY_W = 1 + DATA_W + CNT_W;

  // One outstanding response: store flag, captured load word, cycles left to wait.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  cnt;
  } resp_entry_t;

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_sram_responder_queue.sv
// In-order response queue: DEPTH-entry circular FIFO, each entry counting down to its due cycle.
// Latency: an entry pushed in cycle T is visible at the head from T+1.
// Backpressure: pushes while full and pops of a not-yet-due head are ignored.
module sram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  resp_entry_t                push_entry,
  input  logic                       pop,
  output logic                       head_due,
  output resp_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  resp_entry_t      entry_q [DEPTH];
  resp_entry_t      entry_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign head_entry = entry_q[rd_ptr_q];
  assign head_due   = vld_q[rd_ptr_q] && (entry_q[rd_ptr_q].cnt == '0);
  assign count      = count_q;
  assign push_ok    = push_vld && (count_q < OCC_W'(DEPTH));
  assign pop_ok     = pop && head_due;

  // Next state: age every waiting entry, retire the head, append the new entry.
  always_comb begin
    entry_d  = entry_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (entry_q[i].cnt != '0)) begin
        entry_d[i].cnt = entry_q[i].cnt - CNT_W'(1);
      end
    end
    if (pop_ok) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    // A push never lands on the popped slot: push needs count<DEPTH, so wr_ptr!=rd_ptr when the head is valid.
    if (push_ok) begin
      entry_d[wr_ptr_q] = push_entry;
      vld_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register; reset drops every outstanding entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side sram-like responder: byte-strobed word array answering each request once, in order.
// Latency: data_ok LATENCY cycles after accept, later only if older responses are still queued.
// Backpressure: addr_ok drops when DEPTH requests are outstanding (and, with DATA_SRAM_STALL_EN, on LFSR bit 0 low).
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [OCC_W-1:0]  occ;
  logic              has_room;
  logic              accept;
  logic              head_due;
  resp_entry_t       head_entry;
  resp_entry_t       push_entry;

  // Size is informational and the address aliases above the array, so these bits are deliberately dropped.
  logic unused_in_bits;
  assign unused_in_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign idx      = data_sram_addr[ADDR_W+1:2];
  assign has_room = !reset && (occ < OCC_W'(DEPTH));

`ifdef DATA_SRAM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running pseudo-random stall source.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign data_sram_addr_ok = has_room && lfsr_q[0];
`else
  assign data_sram_addr_ok = has_room;
`endif

  assign accept = data_sram_req && data_sram_addr_ok;

  // Loads snapshot the word before this cycle's edge; loads and stores never share an accept cycle.
  always_comb begin
    push_entry       = '0;
    push_entry.wr    = data_sram_wr;
    push_entry.rdata = data_sram_wr ? 32'h0 : mem_q[idx];
    push_entry.cnt   = CNT_W'(LATENCY - 1);
  end

  // Byte-lane store into the array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  sram_resp_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push_vld   (accept),
    .push_entry (push_entry),
    .pop        (data_sram_data_ok),
    .head_due   (head_due),
    .head_entry (head_entry),
    .count      (occ)
  );

  // Responses are masked during reset so discarded entries never surface.
  assign data_sram_data_ok = !reset && head_due;
  assign data_sram_rdata   = (data_sram_data_ok && !head_entry.wr) ? head_entry.rdata : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam int NRAND = 200;
  localparam int NPRE  = 8;

  logic        clk;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic        req3, wr3;
  logic [3:0]  wstrb3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        addr_ok3, data_ok3;

  int n_checks = 0;
  int n_fail   = 0;

  data_sram_responder u_dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  data_sram_responder #(.LATENCY(3), .DEPTH(2)) u_dut3 (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req3),
    .data_sram_wr      (wr3),
    .data_sram_size    (2'd2),
    .data_sram_wstrb   (wstrb3),
    .data_sram_addr    (addr3),
    .data_sram_wdata   (wdata3),
    .data_sram_addr_ok (addr_ok3),
    .data_sram_data_ok (data_ok3),
    .data_sram_rdata   (rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    req = r; wr = w; addr = a; wstrb = s; wdata = d;
  endtask

  task automatic drv3(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    req3 = r; wr3 = w; addr3 = a; wstrb3 = s; wdata3 = d;
  endtask

  logic [31:0] pre3 [3];
  logic [31:0] ref_mem [NPRE];
  logic [31:0] expq [$];
  logic [31:0] e;
  int issued, acc, resp, cyc, occ, spurious, stall_seen, ix;
  logic have;

  initial begin
    pre3[0] = 32'hA0A0_A0A0;
    pre3[1] = 32'hB1B1_B1B1;
    pre3[2] = 32'hC2C2_C2C2;
    size = 2'd2;
    reset = 1'b1;
    drv(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    drv3(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset held with requests pending: nothing accepted, nothing answered.
    for (int i = 0; i < 2; i++) begin
      tick();
      sample();
      chk1("rst_addr_ok", addr_ok, 1'b0);
      chk1("rst_data_ok", data_ok, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk1("rst_addr_ok3", addr_ok3, 1'b0);
    end
    tick();
    reset = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sample();
    chk1("post_rst_data_ok", data_ok, 1'b0);

`ifndef DATA_SRAM_STALL_EN
    chk1("post_rst_addr_ok", addr_ok, 1'b1);
    chk1("post_rst_addr_ok3", addr_ok3, 1'b1);

    // Full store then load at 0x10, latency 1.
    tick(); drv(1'b1, 1'b1, 32'h10, 4'hF, 32'h1122_3344); sample();
    chk1("st_acc", addr_ok, 1'b1);
    tick(); drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); sample();
    chk1("st_data_ok", data_ok, 1'b1);
    chk("st_rdata", rdata, 32'h0);
    chk1("ld_acc", addr_ok, 1'b1);
    tick(); drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    chk1("ld_data_ok", data_ok, 1'b1);
    chk("ld_rdata", rdata, 32'h1122_3344);
    tick(); sample();
    chk1("empty_data_ok", data_ok, 1'b0);
    chk("empty_rdata", rdata, 32'h0);

    // Single-lane store merges into the existing word.
    tick(); drv(1'b1, 1'b1, 32'h10, 4'b0100, 32'h00AB_0000); sample();
    tick(); drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); sample();
    tick(); drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    chk("lane_merge", rdata, 32'h11AB_3344);

    // Zero-strobe store is answered but changes nothing.
    tick(); drv(1'b1, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF); sample();
    tick(); drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); sample();
    chk1("st0_data_ok", data_ok, 1'b1);
    tick(); drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    chk("st0_unchanged", rdata, 32'h11AB_3344);

    // Load accepted before a store sees the old word; a later load sees the new one.
    tick(); drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); sample();
    tick(); drv(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF); sample();
    chk("ld_before_st", rdata, 32'h11AB_3344);
    tick(); drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); sample();
    chk1("st2_data_ok", data_ok, 1'b1);
    chk("st2_rdata", rdata, 32'h0);
    tick(); drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    chk("ld_after_st", rdata, 32'hDEAD_BEEF);

    // Upper address bits alias onto the same word.
    tick(); drv(1'b1, 1'b0, 32'h1010, 4'h0, 32'h0); sample();
    tick(); drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    chk("alias", rdata, 32'hDEAD_BEEF);

    // Latency-3 instance: preload three words, each store answered 3 cycles later.
    for (int i = 0; i < 3; i++) begin
      tick(); drv3(1'b1, 1'b1, 32'h20 + 32'(4*i), 4'hF, pre3[i]); sample();
      tick(); drv3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
      chk1("pre3_early", data_ok3, 1'b0);
      tick(); sample();
      tick(); sample();
      chk1("pre3_data_ok", data_ok3, 1'b1);
    end

    // Three back-to-back loads against DEPTH=2.
    tick(); drv3(1'b1, 1'b0, 32'h20, 4'h0, 32'h0); sample();
    chk1("b_acc0", addr_ok3, 1'b1);
    tick(); addr3 = 32'h24; sample();
    chk1("b_acc1", addr_ok3, 1'b1);
    tick(); addr3 = 32'h28; sample();
    chk1("b_full_c2", addr_ok3, 1'b0);
    chk1("b_dok_c2", data_ok3, 1'b0);
    tick(); sample();
    chk1("b_full_c3", addr_ok3, 1'b0);
    chk1("b_dok_c3", data_ok3, 1'b1);
    chk("b_rd0", rdata3, 32'hA0A0_A0A0);
    tick(); sample();
    chk1("b_acc2", addr_ok3, 1'b1);
    chk1("b_dok_c4", data_ok3, 1'b1);
    chk("b_rd1", rdata3, 32'hB1B1_B1B1);
    tick(); drv3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    chk1("b_dok_c5", data_ok3, 1'b0);
    tick(); sample();
    chk1("b_dok_c6", data_ok3, 1'b0);
    tick(); sample();
    chk1("b_dok_c7", data_ok3, 1'b1);
    chk("b_rd2", rdata3, 32'hC2C2_C2C2);

    // Reset with a store and a load outstanding: both responses are dropped, the store persists.
    tick(); drv3(1'b1, 1'b1, 32'h30, 4'hF, 32'h5A5A_1234); sample();
    tick(); drv3(1'b1, 1'b0, 32'h20, 4'h0, 32'h0); sample();
    chk1("r_acc_ld", addr_ok3, 1'b1);
    tick(); drv3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); reset = 1'b1; sample();
    chk1("r_dok_in_rst0", data_ok3, 1'b0);
    tick(); sample();
    chk1("r_dok_in_rst1", data_ok3, 1'b0);
    tick(); reset = 1'b0; sample();
    chk1("r_addr_ok_after", addr_ok3, 1'b1);
    chk1("r_dok_after0", data_ok3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); sample();
      chk1("r_dok_after", data_ok3, 1'b0);
    end
    tick(); drv3(1'b1, 1'b0, 32'h30, 4'h0, 32'h0); sample();
    tick(); drv3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); sample();
    tick(); sample();
    tick(); sample();
    chk1("r_readback_ok", data_ok3, 1'b1);
    chk("r_readback", rdata3, 32'h5A5A_1234);
`endif

    // Random traffic on the latency-1 instance, checked against an array model and an in-order queue.
    issued = 0; acc = 0; resp = 0; cyc = 0; spurious = 0; stall_seen = 0; have = 1'b0;
    while ((issued < NPRE + NRAND || expq.size() != 0) && cyc < 5000) begin
      cyc++;
      tick();
      if (!have && issued < NPRE + NRAND) begin
        if (issued < NPRE) begin
          drv(1'b1, 1'b1, 32'(4*issued), 4'hF, $urandom);
        end else begin
          drv(1'b1, 1'($urandom_range(0, 1)), 32'(4*$urandom_range(0, NPRE-1)),
              4'($urandom_range(0, 15)), $urandom);
        end
        have = 1'b1;
      end else if (!have) begin
        req = 1'b0;
      end
      sample();
      occ = acc - resp;
      if (data_ok) begin
        if (expq.size() == 0) spurious++;
        else begin
          e = expq.pop_front();
          chk("rand_rdata", rdata, e);
          resp++;
        end
      end else begin
        chk("rand_idle_rdata", rdata, 32'h0);
      end
      if (req && addr_ok) begin
        ix = int'(addr[4:2]);
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) ref_mem[ix][8*b +: 8] = wdata[8*b +: 8];
          end
          expq.push_back(32'h0);
        end else begin
          expq.push_back(ref_mem[ix]);
        end
        acc++;
        issued++;
        have = 1'b0;
      end else if (req && occ < 2) begin
        stall_seen++;
      end
    end
    chk("rand_accepted", 32'(acc), 32'(NPRE + NRAND));
    chk("rand_responses", 32'(resp), 32'(acc));
    chk("rand_spurious", 32'(spurious), 32'h0);
`ifdef DATA_SRAM_STALL_EN
    chk1("rand_stall_seen", stall_seen > 0, 1'b1);
`else
    chk("rand_no_stall", 32'(stall_seen), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
